// File: rtl/mux2.sv
// Control-steered merge of two 4-phase bundled-data channels onto one output.
// The control channel picks the source; all outputs are registered.
module mux2 #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_i,
  output logic         a0_i,
  input  logic [N-1:0] d0_i,
  input  logic         r1_i,
  output logic         a1_i,
  input  logic [N-1:0] d1_i,
  input  logic         rctl_i,
  input  logic         dctl_i,
  output logic         actl_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  state_e         state_q, state_d;
  logic           sel_q, sel_d;
  logic [N-1:0]   d_q, d_d;
  logic           r_q, r_d;
  logic           a0_q, a0_d;
  logic           a1_q, a1_d;
  logic           actl_q, actl_d;
  logic           req_cur;
  logic           req_sel;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    d_d     = d_q;
    // request of the channel currently named by dctl_i (IDLE) or by sel_q (ACK)
    req_cur = dctl_i ? r1_i : r0_i;
    req_sel = sel_q ? r1_i : r0_i;
    unique case (state_q)
      StIdle: begin
        if (rctl_i && req_cur) begin
          sel_d   = dctl_i;
          d_d     = dctl_i ? d1_i : d0_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (a_o) state_d = StAck;
      end
      StAck: begin
        if (!a_o && !rctl_i && !req_sel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // outputs are a registered Moore decode of the next state
    r_d    = (state_d == StReq);
    actl_d = (state_d == StAck);
    a0_d   = actl_d & ~sel_d;
    a1_d   = actl_d & sel_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      d_q     <= '0;
      r_q     <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      actl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      r_q     <= r_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      actl_q  <= actl_d;
    end
  end

  assign r_o    = r_q;
  assign a0_i   = a0_q;
  assign a1_i   = a1_q;
  assign actl_i = actl_q;
  assign d_o    = d_q;

endmodule
